// File: rtl/booth_seq_multiplier.sv
// Sequential radix-4 Booth multiplier. It retires one Booth digit per clock and
// uses a start/done handshake. Signed or unsigned operation is chosen per
// request through is_signed_i.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   start_i      request a new multiply; accepted only while busy_o=0
//   is_signed_i  1 = two's-complement operands, 0 = unsigned; sampled with start_i
//   x_i, y_i     multiplicand / multiplier; sampled with start_i
//   busy_o       operation in progress; start_i is ignored
//   done_o       one-cycle pulse; product_o is valid from this cycle onward
//   product_o    x*y; holds its value until the next done_o
module booth_seq_multiplier #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 is_signed_i,
  input  logic [WIDTH-1:0]     x_i,
  input  logic [WIDTH-1:0]     y_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [2*WIDTH-1:0]   product_o
);

  localparam int unsigned Iter = (WIDTH + 2) / 2;
  localparam int unsigned AccW = 2 * WIDTH + 4;
  localparam int unsigned CntW = (Iter > 1) ? $clog2(Iter) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e               state_q, state_d;
  logic [AccW-1:0]      xa_q, xa_d;       // multiplicand, pre-shifted by 2i
  logic [WIDTH+1:0]     ye_q, ye_d;       // extended multiplier, consumed 2 bits/cycle
  logic                 yprev_q, yprev_d; // y[2i-1] of the current triple
  logic [AccW-1:0]      acc_q, acc_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic [2:0]           triple;
  logic [AccW-1:0]      addend;
  logic                 load;
  logic                 xs, ys;

  assign triple = {ye_q[1:0], yprev_q};
  assign xs     = is_signed_i & x_i[WIDTH-1];
  assign ys     = is_signed_i & y_i[WIDTH-1];
  // A new operation can be accepted in IDLE and in DONE (back-to-back).
  assign load   = start_i && (state_q != StRun);

  // Negation is done over the full accumulator width, so -2X of the most
  // negative operand cannot truncate.
  always_comb begin
    addend = '0;
    case (triple)
      3'b001, 3'b010: addend = xa_q;
      3'b011:         addend = xa_q << 1;
      3'b100:         addend = ~(xa_q << 1) + AccW'(1);
      3'b101, 3'b110: addend = ~xa_q + AccW'(1);
      default:        addend = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    xa_d      = xa_q;
    ye_d      = ye_q;
    yprev_d   = yprev_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    product_d = product_q;

    unique case (state_q)
      StIdle: ;
      StRun: begin
        acc_d   = acc_q + addend;
        xa_d    = xa_q << 2;
        ye_d    = ye_q >> 2;
        yprev_d = ye_q[1];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CntW'(Iter - 1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        product_d = acc_q[2*WIDTH-1:0];
        done_d    = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      xa_d    = {{(AccW - WIDTH){xs}}, x_i};
      ye_d    = {{2{ys}}, y_i};
      yprev_d = 1'b0;
      acc_d   = '0;
      cnt_d   = '0;
      state_d = StRun;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      xa_q      <= '0;
      ye_q      <= '0;
      yprev_q   <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      xa_q      <= xa_d;
      ye_q      <= ye_d;
      yprev_q   <= yprev_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  // The top guard bits only absorb carries; the low 2*WIDTH bits are exact.
  logic unused_acc;
  assign unused_acc = ^acc_q[AccW-1:2*WIDTH];

  assign busy_o    = (state_q == StRun);
  assign done_o    = done_q;
  assign product_o = product_q;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
module tb_booth_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] x = '0;
  logic [31:0] y = '0;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int n_vec = 0;
  int n_err = 0;

  booth_seq_multiplier #(.WIDTH(32)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .is_signed_i (is_signed),
    .x_i         (x),
    .y_i         (y),
    .busy_o      (busy),
    .done_o      (done),
    .product_o   (product)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Drive a request for one edge, then scramble the inputs to show they are latched.
  task automatic start_op(input logic s, input logic [31:0] a, input logic [31:0] b);
    is_signed = s;
    x         = a;
    y         = b;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    x         = $urandom;
    y         = $urandom;
    is_signed = 1'($urandom_range(0, 1));
    check_eq("busy_after_start", 64'(busy), 64'd1);
  endtask

  // Counts rising edges until done is seen #1 after an edge; bounded.
  task automatic wait_done(input logic hold_chk, input logic [63:0] hold_val, output int cyc);
    cyc = 0;
    while (!done && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (!done && hold_chk) check_eq("product_hold", product, hold_val);
    end
    if (!done) check_eq("done_timeout", 64'(done), 64'd1);
  endtask

  task automatic run_op(input string tag, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    int cyc;
    start_op(s, a, b);
    wait_done(1'b0, 64'd0, cyc);
    check_eq({tag, "_latency"}, 64'(cyc), 64'd18);
    check_eq(tag, product, exp);
    @(posedge clk);
    #1;
    check_eq({tag, "_done_pulse"}, 64'(done), 64'd0);
    check_eq({tag, "_product_held"}, product, exp);
  endtask

  initial begin
    int cyc;
    int ndone;

    // Reset
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_product", product, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic signed
    run_op("s_2x-5", 1'b1, 32'd2, -32'sd5, -64'sd10);
    run_op("s_-20x-11", 1'b1, -32'sd20, -32'sd11, 64'd220);
    run_op("s_-3x21", 1'b1, -32'sd3, 32'd21, -64'sd63);

    // Extremes
    run_op("s_maxxmin", 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000);
    run_op("s_minxmin", 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    run_op("u_ffxff", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run_op("s_ffxff", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1);

    // Start while busy is ignored
    start_op(1'b0, 32'd100, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; x = 32'd7; y = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(1'b0, 64'd0, cyc);
    check_eq("ign_latency", 64'(cyc + 4), 64'd18);
    check_eq("ign_product", product, 64'd0);
    ndone = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check_eq("ign_extra_done", 64'(ndone), 64'd0);
    check_eq("ign_idle_busy", 64'(busy), 64'd0);

    // Start during the done cycle
    start_op(1'b0, 32'd65535, 32'd1);
    wait_done(1'b0, 64'd0, cyc);
    check_eq("b2b_first", product, 64'd65535);
    start_op(1'b0, 32'd6, 32'd7);
    wait_done(1'b1, 64'd65535, cyc);
    check_eq("b2b_gap", 64'(cyc + 1), 64'd19);
    check_eq("b2b_second", product, 64'd42);

    // Reset mid-operation
    @(negedge clk);
    start_op(1'b1, 32'd1000, 32'd3);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_done", 64'(done), 64'd0);
    check_eq("abort_product", product, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check_eq("abort_no_done", 64'(ndone), 64'd0);
    run_op("post_abort", 1'b1, 32'd3, -32'sd7, -64'sd21);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
